move_recorder: RTL and testbench



---
 rtl/move_recorder_pkg.sv | 27 ++
 rtl/move_recorder_btn_debounce.sv | 44 ++++
 rtl/move_recorder.sv | 111 +++++++++++
 tb/tb_move_recorder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/move_recorder_pkg.sv
// Shared definitions for the move recorder: move codes, FSM states and the default slot count.
package move_recorder_pkg;

  localparam int MAX_MOVES_DEF = 17;

  typedef enum logic [1:0] {
    MV_UP    = 2'd0,
    MV_DOWN  = 2'd1,
    MV_RIGHT = 2'd2,
    MV_LEFT  = 2'd3
  } move_t;

  typedef enum logic [1:0] {
    REC  = 2'd0,
    FULL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Direction events packed as {left, right, down, up}; the highest-priority one wins.
  function automatic move_t pick_move(input logic [3:0] dir);
    if (dir[0])      return MV_UP;
    else if (dir[1]) return MV_DOWN;
    else if (dir[2]) return MV_RIGHT;
    else             return MV_LEFT;
  endfunction

endpackage

// File: rtl/move_recorder_btn_debounce.sv
// One pushbutton: 2-flop synchronizer, stability counter and a one-cycle pulse on an accepted press.
module move_recorder_btn_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          level;
  logic [CW-1:0] stable_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == LAST) begin
        // DB_CYCLES-th consecutive differing sample: accept it, pulse only on 0->1.
        level      <= sync_q2;
        stable_cnt <= '0;
        press      <= sync_q2;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_recorder.sv
// Debounced pushbutton entry of up to MAX_MOVES 2-bit moves packed into ord.
// Optional undo button enabled by defining MOVE_UNDO_EN.
module move_recorder
  import move_recorder_pkg::*;
#(
  parameter int MAX_MOVES = MAX_MOVES_DEF,
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_right,
  input  logic                   btn_left,
  input  logic                   btn_enter,
  input  logic                   btn_clear,
  input  logic                   btn_undo,
  output logic [2*MAX_MOVES-1:0] ord,
  output logic [CNT_W-1:0]       cnt,
  output logic                   comp,
  output logic                   ovf
);

  localparam int ORD_W = 2 * MAX_MOVES;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(MAX_MOVES - 1);

  // Event order inside the vector: {clear, enter, left, right, down, up}.
  logic [5:0] raw;
  logic [5:0] ev;
  logic       ev_undo;
  state_t     state;

  assign raw = {btn_clear, btn_enter, btn_left, btn_right, btn_down, btn_up};

  for (genvar i = 0; i < 6; i++) begin : g_btn
    move_recorder_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (raw[i]),
      .press (ev[i])
    );
  end

`ifdef MOVE_UNDO_EN
  move_recorder_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_undo (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_undo),
    .press (ev_undo)
  );
`else
  logic unused_undo;
  assign unused_undo = btn_undo;
  assign ev_undo     = 1'b0;
`endif

  logic             ev_dir;
  logic [ORD_W-1:0] wr_bits;
  logic [ORD_W-1:0] undo_mask;
  logic [CNT_W-1:0] cnt_m1;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ev_dir    = |ev[3:0];
    cnt_m1    = cnt - 1'b1;
    wr_bits   = ORD_W'(pick_move(ev[3:0])) << {cnt, 1'b0};
    undo_mask = ORD_W'(2'b11) << {cnt_m1, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= REC;
      ord   <= '0;
      cnt   <= '0;
      comp  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (ev[5]) begin
        state <= REC;
        ord   <= '0;
        cnt   <= '0;
        comp  <= 1'b0;
      end else if (ev[4]) begin
        if ((state == REC && cnt != '0) || state == FULL) begin
          state <= DONE;
          comp  <= 1'b1;
        end
      end else if (ev_undo) begin
        if (state != DONE && cnt != '0) begin
          ord   <= ord & ~undo_mask;
          cnt   <= cnt_m1;
          state <= REC;
        end
      end else if (ev_dir) begin
        // Lower-priority direction events in the same cycle are dropped, not queued.
        case (state)
          REC: begin
            ord <= ord | wr_bits;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_SLOT) state <= FULL;
          end
          FULL:    ovf <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_recorder.sv
// Directed self-checking bench for move_recorder with DB_CYCLES=4; undo steps run when MOVE_UNDO_EN is defined.
module tb_move_recorder;

  localparam int MAXM = 17;
  localparam int DB   = 4;

  // Button vector: {undo, clear, enter, left, right, down, up}
  localparam logic [6:0] B_UP = 7'd1, B_DOWN = 7'd2, B_RIGHT = 7'd4, B_LEFT = 7'd8;
  localparam logic [6:0] B_ENTER = 7'd16, B_CLEAR = 7'd32, B_UNDO = 7'd64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  btns = '0;
  logic [33:0] ord;
  logic [4:0]  cnt;
  logic        comp;
  logic        ovf;

  int checks = 0;
  int failures = 0;
  int cnt_changes = 0;
  int ovf_cycles = 0;
  int base_chg;
  int base_ovf;
  logic [4:0] prev_cnt = '0;

  always #5 clk = ~clk;

  move_recorder #(.MAX_MOVES(MAXM), .DB_CYCLES(DB), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up    (btns[0]),
    .btn_down  (btns[1]),
    .btn_right (btns[2]),
    .btn_left  (btns[3]),
    .btn_enter (btns[4]),
    .btn_clear (btns[5]),
    .btn_undo  (btns[6]),
    .ord       (ord),
    .cnt       (cnt),
    .comp      (comp),
    .ovf       (ovf)
  );

  always @(negedge clk) begin
    if (cnt !== prev_cnt) cnt_changes++;
    prev_cnt = cnt;
    if (ovf === 1'b1) ovf_cycles++;
  end

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [6:0] mask, input int hold);
    @(negedge clk) btns = mask;
    repeat (hold) @(negedge clk);
    btns = '0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ord", ord, '0);
    check("rst_cnt", 34'(cnt), '0);
    check("rst_comp", 34'(comp), '0);
    check("rst_ovf", 34'(ovf), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three distinct moves
    base_chg = cnt_changes;
    press(B_UP, 10);
    press(B_RIGHT, 10);
    press(B_LEFT, 10);
    check("seq_cnt", 34'(cnt), 34'd3);
    check("seq_ord", ord, 34'b11_10_00);
    check("seq_comp", 34'(comp), '0);
    check("seq_updates", 34'(cnt_changes - base_chg), 34'd3);

    // Bouncy DOWN yields one move
    press(B_CLEAR, 10);
    check("clr_cnt", 34'(cnt), '0);
    base_chg = cnt_changes;
    @(negedge clk) btns = B_DOWN;
    @(negedge clk) btns = '0;
    @(negedge clk) btns = B_DOWN;
    @(negedge clk) btns = '0;
    press(B_DOWN, 10);
    check("bounce_cnt", 34'(cnt), 34'd1);
    check("bounce_ord", ord, 34'b01);
    check("bounce_updates", 34'(cnt_changes - base_chg), 34'd1);

    // Fill the buffer, then one extra move overflows
    press(B_CLEAR, 10);
    base_ovf = ovf_cycles;
    for (int i = 0; i < MAXM; i++) press(B_DOWN, 10);
    check("full_ovf_none", 34'(ovf_cycles - base_ovf), '0);
    press(B_UP, 10);
    check("full_cnt", 34'(cnt), 34'd17);
    check("full_ord", ord, 34'h1_5555_5555);
    check("full_ovf_once", 34'(ovf_cycles - base_ovf), 34'd1);
    press(B_ENTER, 10);
    check("full_enter_comp", 34'(comp), 34'd1);

    // Enter on empty buffer, then a real entry and a locked DONE
    press(B_CLEAR, 10);
    check("clr2_comp", 34'(comp), '0);
    press(B_ENTER, 10);
    check("empty_enter_comp", 34'(comp), '0);
    press(B_LEFT, 10);
    press(B_ENTER, 10);
    check("done_comp", 34'(comp), 34'd1);
    check("done_ord", ord, 34'b11);
    base_ovf = ovf_cycles;
    press(B_RIGHT, 10);
    check("done_locked_ord", ord, 34'b11);
    check("done_locked_cnt", 34'(cnt), 34'd1);
    check("done_no_ovf", 34'(ovf_cycles - base_ovf), '0);
    press(B_CLEAR, 10);
    check("clr3_ord", ord, '0);
    check("clr3_cnt", 34'(cnt), '0);
    check("clr3_comp", 34'(comp), '0);

    // Simultaneous UP and LEFT: UP wins
    press(B_UP | B_LEFT, 10);
    check("prio_cnt", 34'(cnt), 34'd1);
    check("prio_ord", ord, '0);

    // Reset while RIGHT is held
    press(B_CLEAR, 10);
    @(negedge clk) btns = B_RIGHT;
    repeat (10) @(negedge clk);
    check("hold_pre_rst_cnt", 34'(cnt), 34'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_ord", ord, '0);
    check("midrst_cnt", 34'(cnt), '0);
    check("midrst_comp", 34'(comp), '0);
    check("midrst_ovf", 34'(ovf), '0);
    repeat (12) @(negedge clk);
    check("held_after_rst_cnt", 34'(cnt), 34'd1);
    check("held_after_rst_ord", ord, 34'b10);
    btns = '0;
    repeat (12) @(negedge clk);
    press(B_RIGHT, 10);
    check("repress_cnt", 34'(cnt), 34'd2);
    check("repress_ord", ord, 34'b10_10);

`ifdef MOVE_UNDO_EN
    press(B_CLEAR, 10);
    press(B_UP, 10);
    press(B_RIGHT, 10);
    press(B_UNDO, 10);
    check("undo_cnt", 34'(cnt), 34'd1);
    check("undo_ord", ord, '0);
    press(B_CLEAR, 10);
    for (int i = 0; i < MAXM; i++) press(B_DOWN, 10);
    press(B_UNDO, 10);
    check("undo_full_cnt", 34'(cnt), 34'd16);
    check("undo_full_ord", ord, 34'h0_5555_5555);
    base_ovf = ovf_cycles;
    press(B_LEFT, 10);
    check("undo_rec_cnt", 34'(cnt), 34'd17);
    check("undo_rec_ord", ord, 34'h3_5555_5555);
    check("undo_rec_no_ovf", 34'(ovf_cycles - base_ovf), '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
